// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte width, message layout and the PRGA state encoding.
package arc4_pkg;

    localparam int BYTE_W = 8;

    // Byte 0 of every length-prefixed message holds the payload length.
    localparam logic [BYTE_W-1:0] MSG_LEN_ADDR = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        LEN0,
        LEN1,
        B0,
        B1,
        B2,
        B3,
        B4,
        B5
    } prga_state_t;

endpackage

// File: rtl/arc4_prga.sv
// ARC4 PRGA stage: decrypts length-prefixed ct_mem into pt_mem using the S-box in s_mem.
module arc4_prga
    import arc4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [BYTE_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [BYTE_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [BYTE_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    prga_state_t state_q, state_d;

    logic [BYTE_W-1:0] i_q, i_d;
    logic [BYTE_W-1:0] j_q, j_d;
    logic [BYTE_W-1:0] k_q, k_d;
    logic [BYTE_W-1:0] len_q, len_d;
    logic [BYTE_W-1:0] si_q, si_d;
    logic [BYTE_W-1:0] sj_q, sj_d;
    logic [BYTE_W-1:0] cb_q, cb_d;

    logic [BYTE_W-1:0] i_inc;
    logic [BYTE_W-1:0] j_sum;

    assign i_inc = i_q + 8'd1;
    assign j_sum = j_q + s_rddata;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        cb_d      = cb_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = LEN0;
                end
            end
            LEN0: begin
                ct_addr = MSG_LEN_ADDR;
                state_d = LEN1;
            end
            LEN1: begin
                len_d     = ct_rddata;
                pt_addr   = MSG_LEN_ADDR;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                i_d       = '0;
                j_d       = '0;
                k_d       = 8'd1;
                state_d   = (ct_rddata == '0) ? IDLE : B0;
            end
            B0: begin
                i_d     = i_inc;
                s_addr  = i_inc;
                ct_addr = k_q;
                state_d = B1;
            end
            B1: begin
                si_d    = s_rddata;
                cb_d    = ct_rddata;
                j_d     = j_sum;
                s_addr  = j_sum;
                state_d = B2;
            end
            // Swap is two plain writes; when i==j both write the same value.
            B2: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = B3;
            end
            B3: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = B4;
            end
            B4: begin
                s_addr  = si_q + sj_q;
                state_d = B5;
            end
            B5: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ cb_q;
                pt_wren   = 1'b1;
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = B0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            cb_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            cb_q    <= cb_d;
        end
    end

endmodule

// File: tb/tb_arc4_prga.sv
// Directed bench for arc4_prga with behavioural single-port RAMs and hand-derived vectors.
module tb_arc4_prga;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic       s_wren, pt_wren;
    logic [7:0] s_rddata = 8'h00;
    logic [7:0] ct_rddata = 8'h00;

    arc4_prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       len;
        logic [0:5][7:0]  ct;
        logic [0:5][7:0]  pt;
        logic [7:0]       smode;   // 0: identity S, 1: identity with S[1]=FE, S[FE]=01
        logic [7:0]       ndiff;   // final S entries differing from identity
        logic [0:5][7:0]  da;
        logic [0:5][7:0]  dv;
        logic [7:0]       rdy_cyc;
    } vec_t;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];

    logic [7:0] cap_s_addr = 8'h00, cap_s_wrdata = 8'h00, cap_ct_addr = 8'h00;
    logic [7:0] cap_pt_addr = 8'h00, cap_pt_wrdata = 8'h00;
    logic       cap_s_wren = 1'b0, cap_pt_wren = 1'b0;

    int tests = 0;
    int fails = 0;
    int cnt, pt_writes, s_writes, timing_errs;
    bit hold_en;
    vec_t tv [6];
    vec_t b2b_second;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_caps();
        cap_s_wren  = 1'b0;
        cap_pt_wren = 1'b0;
        cap_s_addr  = 8'h00;
        cap_ct_addr = 8'h00;
    endtask

    // One clock: commit last cycle's RAM actions, present read data, then sample the DUT.
    task automatic step();
        @(posedge clk);
        cnt++;
        #1;
        ct_rddata = ct_mem[cap_ct_addr];
        s_rddata  = s_mem[cap_s_addr];
        if (cap_s_wren) begin
            s_mem[cap_s_addr] = cap_s_wrdata;
            s_writes++;
        end
        if (cap_pt_wren) pt_mem[cap_pt_addr] = cap_pt_wrdata;
        #1;
        if (pt_wren) begin
            pt_writes++;
            if (32'(pt_addr) * 6 + 2 != cnt) timing_errs++;
        end
        cap_s_addr    = s_addr;
        cap_s_wrdata  = s_wrdata;
        cap_s_wren    = s_wren;
        cap_ct_addr   = ct_addr;
        cap_pt_addr   = pt_addr;
        cap_pt_wrdata = pt_wrdata;
        cap_pt_wren   = pt_wren;
    endtask

    task automatic load(input vec_t v);
        for (int a = 0; a < 256; a++) begin
            s_mem[a]  = 8'(a);
            ct_mem[a] = 8'h00;
            pt_mem[a] = 8'hEE;
        end
        if (v.smode == 8'd1) begin
            s_mem[1]   = 8'hFE;
            s_mem[254] = 8'h01;
        end
        for (int n = 0; n < 6; n++) ct_mem[n] = v.ct[n];
    endtask

    task automatic start();
        @(negedge clk);
        en          = 1'b1;
        cnt         = 0;
        pt_writes   = 0;
        s_writes    = 0;
        timing_errs = 0;
        clear_caps();
    endtask

    task automatic wait_rdy(output int rc);
        int n;
        rc = -1;
        n  = 0;
        while (rc < 0 && n < 2000) begin
            step();
            if (n == 0 && !hold_en) en = 1'b0;
            if (rdy) rc = cnt;
            n++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rdy"},     32'(rdy), 32'd1);
        chk({tag, " s_wren"},  32'(s_wren), 32'd0);
        chk({tag, " pt_wren"}, 32'(pt_wren), 32'd0);
        chk({tag, " addrs"},   {8'h00, s_addr, ct_addr, pt_addr}, 32'd0);
    endtask

    task automatic check_mem(input string tag, input vec_t v);
        logic [7:0] exp_s [256];
        int mism;
        for (int n = 0; n <= int'(v.len); n++)
            chk($sformatf("%s pt[%0d]", tag, n), 32'(pt_mem[n]), 32'(v.pt[n]));
        chk($sformatf("%s pt[len+1] untouched", tag), 32'(pt_mem[v.len + 8'd1]), 32'hEE);
        for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
        for (int n = 0; n < int'(v.ndiff); n++) exp_s[v.da[n]] = v.dv[n];
        mism = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== exp_s[a]) mism++;
        chk($sformatf("%s S-box mismatching entries", tag), 32'(mism), 32'd0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int rc;
        load(v);
        hold_en = 1'b0;
        start();
        wait_rdy(rc);
        chk($sformatf("%s rdy cycle", tag), 32'(rc), 32'(v.rdy_cyc));
        step();
        check_mem(tag, v);
        chk($sformatf("%s pt write count", tag), 32'(pt_writes), 32'(v.len) + 32'd1);
        chk($sformatf("%s S write count", tag), 32'(s_writes), 32'(v.len) * 2);
        chk($sformatf("%s pt_wren timing errors", tag), 32'(timing_errs), 32'd0);
    endtask

    initial begin
        int rc;

        //          len    ct                   pt                   smode ndiff da                   dv                   rdy
        tv[0] = '{8'd1, 48'h01_00_00_00_00_00, 48'h01_02_00_00_00_00, 8'd0, 8'd0, 48'h0,               48'h0,               8'd9};
        tv[1] = '{8'd2, 48'h02_00_FF_00_00_00, 48'h02_02_FA_00_00_00, 8'd0, 8'd2, 48'h02_03_00_00_00_00, 48'h03_02_00_00_00_00, 8'd15};
        tv[2] = '{8'd0, 48'h00_00_00_00_00_00, 48'h00_00_00_00_00_00, 8'd0, 8'd0, 48'h0,               48'h0,               8'd3};
        tv[3] = '{8'd3, 48'h03_00_00_00_00_00, 48'h03_02_05_07_00_00, 8'd0, 8'd3, 48'h02_03_05_00_00_00, 48'h03_05_02_00_00_00, 8'd21};
        tv[4] = '{8'd4, 48'h04_11_22_33_44_00, 48'h04_13_27_34_49_00, 8'd0, 8'd5, 48'h02_03_05_04_09_00, 48'h03_05_02_09_04_00, 8'd27};
        tv[5] = '{8'd2, 48'h02_0F_5A_00_00_00, 48'h02_F0_5A_00_00_00, 8'd1, 8'd2, 48'h00_02_00_00_00_00, 48'h02_00_00_00_00_00, 8'd15};
        // Second pass over tv[1]'s ct with the S-box that the first pass left behind.
        b2b_second = '{8'd2, 48'h02_00_FF_00_00_00, 48'h02_03_F8_00_00_00, 8'd0, 8'd3,
                       48'h02_03_04_00_00_00, 48'h04_02_03_00_00_00, 8'd30};

        hold_en = 1'b0;
        for (int a = 0; a < 256; a++) begin
            s_mem[a] = 8'(a); ct_mem[a] = 8'h00; pt_mem[a] = 8'hEE;
        end
        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post-reset");

        for (int t = 0; t < 6; t++) run_vec($sformatf("vec%0d", t), tv[t]);

        // en held high: no restart mid-run, immediate second pass when rdy returns.
        load(tv[1]);
        hold_en = 1'b1;
        start();
        wait_rdy(rc);
        chk("b2b first rdy cycle", 32'(rc), 32'd15);
        step();
        chk("b2b second pass started", 32'(rdy), 32'd0);
        en      = 1'b0;
        hold_en = 1'b0;
        wait_rdy(rc);
        chk("b2b second rdy cycle", 32'(rc), 32'(b2b_second.rdy_cyc));
        step();
        check_mem("b2b", b2b_second);

        // Reset during B2 of byte 1, then a clean rerun.
        load(tv[1]);
        start();
        for (int n = 0; n < 5; n++) begin
            step();
            if (n == 0) en = 1'b0;
        end
        chk("rst pre-check in B2 s_wren", 32'(s_wren), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("mid-run reset");
        clear_caps();
        chk("rst partial pt[0] kept", 32'(pt_mem[0]), 32'h02);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after-reset", tv[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
